// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC serial capture front end: FSM state
// encoding, default geometry of the ADC frame and the frame-length formula
// used to reject configurations whose frame cannot fit in a sample period.
package adc_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_t;

    localparam int DATA_W_DEF        = 14;
    localparam int LEAD_BITS_DEF     = 2;
    localparam int CLK_DIV_DEF       = 2;
    localparam int CONV_CYCLES_DEF   = 4;
    localparam int SAMPLE_PERIOD_DEF = 100;

    // Bits clocked out of the ADC per frame: lead bits followed by data.
    localparam int N_BITS = LEAD_BITS_DEF + DATA_W_DEF;

    function automatic int calc_n_bits(input int lead_bits, input int data_w);
        return lead_bits + data_w;
    endfunction

    // clk cycles from the cs_n fall up to and including the DONE cycle.
    function automatic int calc_frame_len(input int conv_cycles, input int clk_div,
                                          input int lead_bits, input int data_w);
        return conv_cycles + 2 * clk_div * calc_n_bits(lead_bits, data_w) + 1;
    endfunction

endpackage

// File: rtl/sclk_gen.sv
// SCLK generator for the ADC shift phase. While i_active is high it produces
// CLK_DIV low cycles then CLK_DIV high cycles per bit, a strobe on the clk
// edge that drives SCLK 0->1 (the data capture edge), and a flag on the last
// cycle of the final bit. Everything returns to idle when i_active drops.
module sclk_gen
    import adc_if_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int BITS    = adc_if_pkg::N_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_sclk,
    output logic o_rise_strobe,
    output logic o_last_bit
);

    localparam int              PHW      = $clog2(2 * CLK_DIV);
    localparam logic [PHW-1:0]  PH_RISE  = PHW'(CLK_DIV - 1);
    localparam logic [PHW-1:0]  PH_LAST  = PHW'(2 * CLK_DIV - 1);
    localparam int              BCW      = $clog2(BITS + 1);
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(BITS - 1);

    logic [PHW-1:0] r_phase;
    logic [BCW-1:0] r_bit_cnt;
    logic           r_sclk;

    // Phase and bit counters; SCLK is registered so the ADC sees clean edges.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, matching hardware.
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (r_phase == PH_LAST) begin
            r_phase   <= '0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_sclk    <= 1'b0;
        end else begin
            r_phase <= r_phase + 1'b1;
            if (r_phase == PH_RISE) begin
                r_sclk <= 1'b1;
            end
        end
    end

    assign o_sclk        = r_sclk;
    assign o_rise_strobe = i_active && (r_phase == PH_RISE);
    assign o_last_bit    = i_active && (r_phase == PH_LAST) && (r_bit_cnt == BIT_LAST);

endmodule

// File: rtl/adc_serial_capture.sv
// ADC front end of the FIR chain: starts a conversion every SAMPLE_PERIOD
// clk cycles while enabled, clocks one MSB-first serial frame out of the ADC
// and presents the result as a held parallel word with a one-cycle valid.
// All outputs come straight from flops so nothing downstream sees glitches.
module adc_serial_capture
    import adc_if_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int LEAD_BITS     = LEAD_BITS_DEF,
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int CONV_CYCLES   = CONV_CYCLES_DEF,
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_sdo,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              lead_err,
    output logic              busy
);

    localparam int             NB          = calc_n_bits(LEAD_BITS, DATA_W);
    localparam int             FRAME_LEN   = calc_frame_len(CONV_CYCLES, CLK_DIV, LEAD_BITS, DATA_W);
    localparam int             PW          = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0]  PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam int             CW          = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0]  CONV_LAST   = CW'(CONV_CYCLES - 1);

    // A frame must finish before the next period starts, otherwise a start
    // could land on a frame in progress.
    generate
        if (FRAME_LEN >= SAMPLE_PERIOD) begin : g_frame_too_long
            $error("adc_serial_capture: frame length %0d must be below SAMPLE_PERIOD %0d",
                   FRAME_LEN, SAMPLE_PERIOD);
        end
    endgenerate

    adc_state_t        r_state;
    adc_state_t        w_next_state;
    logic [PW-1:0]     r_period_cnt;
    logic [CW-1:0]     r_conv_cnt;
    logic [NB-1:0]     r_shift;
    logic [DATA_W-1:0] r_sample;
    logic              r_sample_valid;
    logic              r_lead_err;
    logic              r_cs_n;
    logic              r_busy;
    logic              w_shift_active;
    logic              w_sclk;
    logic              w_rise_strobe;
    logic              w_last_bit;
    logic              w_lead_any;

    assign w_shift_active = (r_state == ST_SHIFT);

    sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .BITS    (NB)
    ) u_sclk_gen (
        .clk           (clk),
        .rst           (rst),
        .i_active      (w_shift_active),
        .o_sclk        (w_sclk),
        .o_rise_strobe (w_rise_strobe),
        .o_last_bit    (w_last_bit)
    );

    generate
        if (LEAD_BITS > 0) begin : g_lead
            assign w_lead_any = |r_shift[NB-1:DATA_W];
        end else begin : g_no_lead
            assign w_lead_any = 1'b0;
        end
    endgenerate

    // Sample-period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt == PERIOD_LAST) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    // NOTE: the next state gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (enable && (r_period_cnt == '0)) w_next_state = ST_CONV;
            ST_CONV:  if (r_conv_cnt == CONV_LAST)        w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last_bit)                     w_next_state = ST_DONE;
            ST_DONE:                                      w_next_state = ST_IDLE;
            default:                                      w_next_state = ST_IDLE;
        endcase
    end

    // Conversion wait: counts the cycles cs_n has been low before SCLK starts.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_CONV)) begin
            r_conv_cnt <= '0;
        end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
        end
    end

    // Serial-to-parallel shifter, loaded on each SCLK rising edge.
    // NOTE: no reset here on purpose; every frame overwrites all NB bits before they are used, and rst aborts any frame.
    always_ff @(posedge clk) begin
        if (w_rise_strobe) begin
            r_shift <= {r_shift[NB-2:0], adc_sdo};
        end
    end

    // Output registers, driven from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n         <= 1'b1;
            r_busy         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_lead_err     <= 1'b0;
            r_sample       <= '0;
        end else begin
            r_cs_n         <= !((w_next_state == ST_CONV) || (w_next_state == ST_SHIFT));
            r_busy         <= (w_next_state != ST_IDLE);
            r_sample_valid <= (w_next_state == ST_DONE);
            r_lead_err     <= (w_next_state == ST_DONE) && w_lead_any;
            if (w_next_state == ST_DONE) begin
                r_sample <= r_shift[DATA_W-1:0];
            end
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = w_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign lead_err     = r_lead_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture. A behavioural ADC drives adc_sdo from the
// DUT's cs_n/sclk and pushes the expected result for each frame onto a
// scoreboard; an independent monitor checks every clock for results,
// timing, SCLK shape, busy and a glitch-free held sample.
module tb_adc_serial_capture;

    localparam int DATA_W     = 14;
    localparam int N_BITS     = 16;
    localparam int LATENCY    = 68;
    localparam int FIRST_RISE = 6;
    localparam int PERIOD     = 100;
    localparam int HALF_SCLK  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] sample;
        logic              lead;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              adc_sdo;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              lead_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    logic [15:0] word_q[$];

    adc_serial_capture dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_sdo      (adc_sdo),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .lead_err     (lead_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- behavioural ADC ----------------
    logic        adc_prev_cs_n = 1'b1;
    logic        adc_prev_sclk = 1'b0;
    logic [15:0] adc_word;
    int          adc_idx;

    initial begin
        exp_t e;
        adc_sdo = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (adc_prev_cs_n === 1'b1 && adc_cs_n === 1'b0) begin
                if (word_q.size() > 0) adc_word = word_q.pop_front();
                else                   adc_word = 16'($urandom);
                e.sample = adc_word[DATA_W-1:0];
                e.lead   = (adc_word[15:14] != 2'b00);
                sb_q.push_back(e);
                adc_idx = N_BITS - 1;
                adc_sdo = adc_word[adc_idx];
            end else if (adc_cs_n === 1'b0 && adc_prev_sclk === 1'b1 && adc_sclk === 1'b0) begin
                if (adc_idx > 0) begin
                    adc_idx--;
                    adc_sdo = adc_word[adc_idx];
                end
            end else if (adc_cs_n !== 1'b0) begin
                adc_sdo = 1'($urandom);
            end
            adc_prev_cs_n = adc_cs_n;
            adc_prev_sclk = adc_sclk;
        end
    end

    // ---------------- monitor ----------------
    logic              chk_period    = 1'b0;
    logic              prev_cs_n     = 1'b1;
    logic              prev_sclk     = 1'b0;
    logic              in_frame      = 1'b0;
    logic              prev_valid_ok = 1'b0;
    logic [DATA_W-1:0] exp_hold      = '0;
    int                cyc           = 0;
    int                last_valid_cyc = 0;
    int                frame_cyc     = 0;
    int                rises         = 0;
    int                high_run      = 0;
    int                low_run       = 0;
    int                n_valid       = 0;
    int                n_starts      = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b0) begin
                sb_q.delete();
                exp_hold      = '0;
                in_frame      = 1'b0;
                prev_cs_n     = 1'b1;
                prev_sclk     = 1'b0;
                prev_valid_ok = 1'b0;
            end else begin
                if (prev_cs_n && !adc_cs_n) begin
                    in_frame  = 1'b1;
                    frame_cyc = 0;
                    rises     = 0;
                    high_run  = 0;
                    low_run   = 0;
                    n_starts++;
                end else if (in_frame) begin
                    frame_cyc++;
                end

                if (adc_sclk) begin
                    if (!prev_sclk) begin
                        rises++;
                        if (rises == 1) check("first_sclk_rise_cycle", frame_cyc, FIRST_RISE);
                        else            check("sclk_low_len", low_run, HALF_SCLK);
                        high_run = 0;
                    end
                    high_run++;
                end else begin
                    if (prev_sclk && in_frame) begin
                        check("sclk_high_len", high_run, HALF_SCLK);
                        low_run = 0;
                    end
                    low_run++;
                end
                if (adc_cs_n) check("sclk_idle_cs_high", adc_sclk, 1'b0);

                if (sample_valid) begin
                    n_valid++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: sample_valid with no frame expected at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("sample", sample, e.sample);
                        check("lead_err", lead_err, e.lead);
                        exp_hold = e.sample;
                    end
                    check("latency", in_frame ? frame_cyc : -1, LATENCY);
                    check("sclk_rises", rises, N_BITS);
                    in_frame = 1'b0;
                    if (chk_period && prev_valid_ok) check("valid_period", cyc - last_valid_cyc, PERIOD);
                    last_valid_cyc = cyc;
                    prev_valid_ok  = chk_period;
                end else begin
                    check("sample_hold", sample, exp_hold);
                    check("lead_err_idle", lead_err, 1'b0);
                end
                check("busy", busy, (!adc_cs_n) || sample_valid);
                prev_cs_n = adc_cs_n;
                prev_sclk = adc_sclk;
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_valids(input int n, input int budget, input string name);
        int snap = n_valid;
        int k    = 0;
        while (n_valid < snap + n && k < budget) begin
            step();
            k++;
        end
        check(name, n_valid - snap, n);
    endtask

    task automatic wait_cs_fall(input int budget, input string name);
        int k = 0;
        while (adc_cs_n !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        check(name, adc_cs_n, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int snap_valid;
        int snap_starts;

        rst    = 1'b1;
        enable = 1'b0;
        step(3);
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b0);
        check("rst_sample", sample, '0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_lead_err", lead_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step(5);
        check("idle_disabled_cs_n", adc_cs_n, 1'b1);
        check("idle_disabled_busy", busy, 1'b0);

        // 1: first frame, alternating data, clean lead bits
        word_q.push_back(16'h2AAA);
        enable = 1'b1;
        step(1);
        check("cs_n_fall_after_enable", adc_cs_n, 1'b0);
        check("busy_after_enable", busy, 1'b1);
        wait_valids(1, 120, "t1_valid_seen");

        // 2: continuous enable, fixed period
        chk_period = 1'b1;
        wait_valids(4, 450, "t2_valids_seen");

        // 3: lead bit set, all-ones data
        word_q.push_back(16'h7FFF);
        wait_valids(1, 120, "t3_valid_seen");
        chk_period = 1'b0;

        // 4: drop enable 30 cycles into a frame
        wait_cs_fall(120, "t4_frame_start");
        step(30);
        enable = 1'b0;
        wait_valids(1, 80, "t4_frame_completes");
        snap_valid  = n_valid;
        snap_starts = n_starts;
        step(150);
        check("t4_no_more_valid", n_valid - snap_valid, 0);
        check("t4_no_more_frames", n_starts - snap_starts, 0);
        check("t4_cs_n_high", adc_cs_n, 1'b1);

        // 5: reset 40 cycles into a frame
        enable = 1'b1;
        wait_cs_fall(5, "t5_frame_start");
        step(40);
        snap_valid = n_valid;
        rst = 1'b1;
        step(1);
        check("t5_rst_cs_n", adc_cs_n, 1'b1);
        check("t5_rst_sclk", adc_sclk, 1'b0);
        check("t5_rst_sample", sample, '0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", sample_valid, 1'b0);
        rst = 1'b0;
        wait_cs_fall(5, "t5_restart");
        check("t5_aborted_no_valid", n_valid - snap_valid, 0);
        wait_valids(1, 100, "t5_restart_valid");

        // 6: random frames, sample stability checked every cycle
        chk_period = 1'b1;
        wait_valids(5, 600, "t6_valids_seen");
        chk_period = 1'b0;
        enable     = 1'b0;
        step(120);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
